systolic_output_deskew: RTL and testbench

// - Receives the bottom-edge outputs of the systolic array (psum + valid per column) and re-aligns them into whole rows.
// - Column c of a row arrives c cycles after column 0. This block removes that skew and queues complete rows in a FIFO.
// - Rows leave on a valid/ready stream towards the unified-buffer writeback path.
// - The array cannot stall, so backpressure is absorbed by the FIFO. Rows arriving while the FIFO is full are dropped and flagged.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/sync_fifo.sv | 88 ++++++++
 rtl/systolic_output_deskew.sv | 177 +++++++++++++++++
 tb/tb_systolic_output_deskew.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and types for the systolic array output path.
// SYS_N: array width (output columns); DATA_W: psum width;
// FIFO_DEPTH: aligned-row queue depth; ROW_IDX_W: row index width.
package tpu_pkg;

    localparam int unsigned SYS_N      = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned ROW_IDX_W  = 16;

    typedef logic [DATA_W-1:0] psum_t;
    typedef psum_t row_t [SYS_N];

endpackage : tpu_pkg

// File: rtl/sync_fifo.sv
// Registered first-word-fall-through FIFO.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           sync clear of pointers/count (wins over push/pop)
//   push, push_data write request and payload
//   pop             read request; ignored when empty
//   pop_data_c      head entry straight from storage (0 when empty)
//   full_c, empty_c occupancy flags decoded from count
//   count           registered occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_c    = (count_q == '0);
    assign full_c     = (count_q == CW'(DEPTH));
    assign count      = count_q;
    assign pop_data_c = empty_c ? '0 : mem_q[rd_ptr_q];

    // Pointer/count update; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop & ~empty_c;
        push_ok  = push & (~full_c | pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are masked by count, so no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : sync_fifo

// File: rtl/systolic_output_deskew.sv
// Re-aligns skewed systolic-array bottom-edge outputs into whole rows and
// queues them for unified-buffer writeback.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      sync clear of delay lines, FIFO, row index
//   col_size_in/_valid_in      active column count load (clamped 1..SYS_N)
//   sys_data_in, sys_valid_in  per-column psum/valid, column c skewed by c cycles
//   out_data/out_valid/out_ready  aligned row stream (FWFT head)
//   out_row_idx                index of the head row since reset/flush
//   fifo_count                 queue occupancy
//   overflow, skew_err         sticky error flags
module systolic_output_deskew
    import tpu_pkg::*;
#(
    parameter int unsigned SYS_N      = tpu_pkg::SYS_N,
    parameter int unsigned DATA_W     = tpu_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = tpu_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [31:0]                   col_size_in,
    input  logic                          col_size_valid_in,
    input  logic [SYS_N*DATA_W-1:0]       sys_data_in,
    input  logic [SYS_N-1:0]              sys_valid_in,
    output logic [SYS_N*DATA_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ROW_IDX_W-1:0]          out_row_idx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          skew_err
);

    localparam int unsigned ROW_W = SYS_N * DATA_W;
    localparam int unsigned CS_W  = $clog2(SYS_N + 1);
    localparam int unsigned ENT_W = ROW_W + ROW_IDX_W;

    logic [CS_W-1:0]      col_size_q, col_size_d;
    logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
    logic                 overflow_q, overflow_d;
    logic                 skew_err_q, skew_err_d;

    logic [DATA_W-1:0]    aligned_data [SYS_N];
    logic [SYS_N-1:0]     aligned_vld;
    logic [SYS_N-1:0]     active;
    logic [ROW_W-1:0]     row_data;
    logic                 row_full;
    logic                 row_any;
    logic                 push_req;
    logic                 drop;
    logic                 push_acc;

    logic [ENT_W-1:0]     fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Deskew: column c waits SYS_N-1-c cycles so every column lines up with the last one.
    for (genvar c = 0; c < SYS_N; c++) begin : g_col
        localparam int unsigned D = SYS_N - 1 - c;
        if (D == 0) begin : g_direct
            assign aligned_data[c] = sys_data_in[c*DATA_W +: DATA_W];
            assign aligned_vld[c]  = sys_valid_in[c];
        end else begin : g_delay
            logic [DATA_W-1:0] dat_q [D];
            logic [DATA_W-1:0] dat_d [D];
            logic [D-1:0]      vld_q, vld_d;

            always_comb begin
                dat_d[0] = sys_data_in[c*DATA_W +: DATA_W];
                for (int unsigned k = 1; k < D; k++) begin
                    dat_d[k] = dat_q[k-1];
                end
                vld_d = D'({vld_q, sys_valid_in[c]});
                if (flush) begin
                    vld_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int unsigned k = 0; k < D; k++) begin
                        dat_q[k] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end

            assign aligned_data[c] = dat_q[D-1];
            assign aligned_vld[c]  = vld_q[D-1];
        end
    end

    // Active-column mask and the aligned row with inactive columns zeroed.
    always_comb begin
        active   = '0;
        row_data = '0;
        for (int unsigned c = 0; c < SYS_N; c++) begin
            active[c] = (c < 32'(col_size_q));
            if (active[c]) begin
                row_data[c*DATA_W +: DATA_W] = aligned_data[c];
            end
        end
        row_full = &(aligned_vld | ~active);
        row_any  = |(aligned_vld & active);
    end

    // Push/drop decisions; when full the only free slot comes from a same-cycle pop.
    always_comb begin
        push_req = row_full & ~flush;
        drop     = push_req & fifo_full & ~out_ready;
        push_acc = push_req & ~drop;
    end

    // Column size, row index and sticky flags.
    always_comb begin
        col_size_d = col_size_q;
        row_idx_d  = row_idx_q;
        overflow_d = overflow_q | drop;
        skew_err_d = skew_err_q | (row_any & ~row_full & ~flush);
        if (col_size_valid_in) begin
            if (col_size_in == 32'd0) begin
                col_size_d = CS_W'(1);
            end else if (col_size_in > 32'(SYS_N)) begin
                col_size_d = CS_W'(SYS_N);
            end else begin
                col_size_d = CS_W'(col_size_in);
            end
        end
        if (flush) begin
            row_idx_d = '0;
        end else if (push_acc) begin
            row_idx_d = row_idx_q + ROW_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_size_q <= CS_W'(SYS_N);
            row_idx_q  <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            col_size_q <= col_size_d;
            row_idx_q  <= row_idx_d;
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    // Row index travels with its data so the head always reports its own index.
    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push_req),
        .push_data  ({row_idx_q, row_data}),
        .pop        (out_ready),
        .pop_data_c (fifo_head),
        .full_c     (fifo_full),
        .empty_c    (fifo_empty),
        .count      (fifo_count)
    );

    assign out_data    = fifo_head[ROW_W-1:0];
    assign out_row_idx = fifo_head[ENT_W-1:ROW_W];
    assign out_valid   = ~fifo_empty;
    assign overflow    = overflow_q;
    assign skew_err    = skew_err_q;

endmodule : systolic_output_deskew

// File: tb/tb_systolic_output_deskew.sv
module tb_systolic_output_deskew;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [31:0]     col_size_in;
    logic            col_size_valid_in;
    logic [N*DW-1:0] sys_data_in;
    logic [N-1:0]    sys_valid_in;
    logic [N*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_row_idx;
    logic [3:0]      fifo_count;
    logic            overflow;
    logic            skew_err;

    int n_cmp = 0;
    int n_err = 0;

    systolic_output_deskew dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .col_size_in       (col_size_in),
        .col_size_valid_in (col_size_valid_in),
        .sys_data_in       (sys_data_in),
        .sys_valid_in      (sys_valid_in),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_row_idx       (out_row_idx),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .skew_err          (skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] val(input int base, input int r, input int c);
        return 32'(base + r * 256 + c);
    endfunction

    function automatic logic [N*DW-1:0] row_exp(input int base, input int r, input int ncols);
        logic [N*DW-1:0] res;
        res = '0;
        for (int c = 0; c < ncols; c++) res[c*DW +: DW] = val(base, r, c);
        return res;
    endfunction

    // Drives n skewed rows; row r column c appears on cycle r+c.
    // Columns >= ncols carry data but no valid; skip_row loses its column-1 valid.
    task automatic burst(input int n, input int base, input int skip_row, input int ncols, input int rdy_t);
        for (int t = 0; t < n + int'(N) - 1; t++) begin
            logic [N-1:0]    v;
            logic [N*DW-1:0] d;
            v = '0;
            d = '0;
            for (int c = 0; c < int'(N); c++) begin
                int r;
                r = t - c;
                if (r >= 0 && r < n) begin
                    d[c*DW +: DW] = val(base, r, c);
                    if (c < ncols && !(r == skip_row && c == 1)) v[c] = 1'b1;
                end
            end
            sys_data_in  = d;
            sys_valid_in = v;
            out_ready    = (t == rdy_t);
            tick();
        end
        sys_data_in  = '0;
        sys_valid_in = '0;
        out_ready    = 1'b0;
    endtask

    task automatic load_col_size(input logic [31:0] v);
        col_size_in       = v;
        col_size_valid_in = 1'b1;
        tick();
        col_size_valid_in = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        flush             = 1'b0;
        col_size_in       = '0;
        col_size_valid_in = 1'b0;
        sys_data_in       = '0;
        sys_valid_in      = '0;
        out_ready         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_skew_err", skew_err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_row_idx", out_row_idx, 0);

        // Single row, latency SYS_N, push+pop-when-empty gives count 1
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sys_valid_in = 4'(1 << t);
            sys_data_in  = '0;
            sys_data_in[t*DW +: DW] = 32'((t + 1) * 10);
            if (t == 3) chk("single_not_early", out_valid, 0);
            tick();
        end
        sys_valid_in = '0;
        sys_data_in  = '0;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, {32'd40, 32'd30, 32'd20, 32'd10});
        chk("single_idx", out_row_idx, 0);
        chk("single_count", fifo_count, 1);
        tick();
        chk("single_popped", out_valid, 0);
        out_ready = 1'b0;

        // Flush resets the row index
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Burst of 12 rows into an 8-deep FIFO with no consumer
        burst(12, 32'h100, -1, 4, -1);
        chk("burst_count", fifo_count, 8);
        chk("burst_overflow", overflow, 1);
        chk("burst_skew", skew_err, 0);
        tick();
        tick();
        chk("burst_hold_data", out_data, row_exp(32'h100, 0, 4));
        chk("burst_hold_idx", out_row_idx, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid_%0d", i), out_valid, 1);
            chk($sformatf("drain_data_%0d", i), out_data, row_exp(32'h100, i, 4));
            chk($sformatf("drain_idx_%0d", i), out_row_idx, 16'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_count", fifo_count, 0);

        // Reset to clear sticky flags, then full FIFO with simultaneous push+pop
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2_overflow", overflow, 0);
        burst(8, 32'h1000, -1, 4, -1);
        chk("full_count", fifo_count, 8);
        chk("full_overflow", overflow, 0);
        burst(1, 32'h2000, -1, 4, 3);
        chk("pushpop_count", fifo_count, 8);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_head_idx", out_row_idx, 1);
        chk("pushpop_head_data", out_data, row_exp(32'h1000, 1, 4));
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("pp_idx_%0d", i), out_row_idx, 16'(i));
            tick();
        end
        chk("pp_last_idx", out_row_idx, 8);
        chk("pp_last_data", out_data, row_exp(32'h2000, 0, 4));
        tick();
        out_ready = 1'b0;
        chk("pp_empty", out_valid, 0);

        // col_size = 2: columns 2/3 never valid, forced to zero
        load_col_size(32'd2);
        burst(3, 32'h3000, -1, 2, -1);
        chk("cs2_count", fifo_count, 3);
        chk("cs2_skew", skew_err, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cs2_data_%0d", i), out_data, row_exp(32'h3000, i, 2));
            chk($sformatf("cs2_idx_%0d", i), out_row_idx, 16'(9 + i));
            tick();
        end
        out_ready = 1'b0;

        // col_size = 0 behaves as 1
        load_col_size(32'd0);
        burst(1, 32'h4000, -1, 1, -1);
        chk("cs0_count", fifo_count, 1);
        chk("cs0_data", out_data, row_exp(32'h4000, 0, 1));
        chk("cs0_idx", out_row_idx, 12);
        chk("cs0_skew", skew_err, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // col_size above SYS_N clamps to SYS_N; missing column 1 on one row
        load_col_size(32'd9);
        burst(3, 32'h5000, 1, 4, -1);
        chk("skew_count", fifo_count, 2);
        chk("skew_flag", skew_err, 1);
        chk("skew_row0_idx", out_row_idx, 13);
        chk("skew_row0_data", out_data, row_exp(32'h5000, 0, 4));
        out_ready = 1'b1;
        tick();
        chk("skew_row2_idx", out_row_idx, 14);
        chk("skew_row2_data", out_data, row_exp(32'h5000, 2, 4));
        tick();
        out_ready = 1'b0;
        chk("skew_drained", out_valid, 0);

        // Flush with 3 rows queued and a partial row in flight
        burst(3, 32'h6000, -1, 4, -1);
        chk("fl_pre_count", fifo_count, 3);
        sys_valid_in = 4'b0001;
        sys_data_in  = '0;
        sys_data_in[0 +: DW] = 32'hdead;
        tick();
        sys_valid_in = 4'b0010;
        sys_data_in  = '0;
        sys_data_in[DW +: DW] = 32'hbeef;
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        sys_valid_in = '0;
        sys_data_in  = '0;
        chk("fl_count", fifo_count, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_data", out_data, 0);
        chk("fl_skew_kept", skew_err, 1);
        repeat (4) tick();
        chk("fl_partial_lost", fifo_count, 0);
        burst(1, 32'h7000, -1, 4, -1);
        chk("fl_next_idx", out_row_idx, 0);
        chk("fl_next_data", out_data, row_exp(32'h7000, 0, 4));
        chk("fl_next_count", fifo_count, 1);

        // Asynchronous reset mid-row
        sys_valid_in = 4'b0001;
        sys_data_in[0 +: DW] = 32'h1234;
        tick();
        sys_valid_in = 4'b0010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", out_row_idx, 0);
        chk("arst_skew", skew_err, 0);
        chk("arst_overflow", overflow, 0);
        sys_valid_in = '0;
        sys_data_in  = '0;
        rst_n        = 1'b1;
        repeat (5) tick();
        chk("arst_partial_lost", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_systolic_output_deskew
